// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Ethernet TX byte stream between NUM_REQ sources.
// Grants whole frames, inserts an inter-frame gap and aborts frames whose source stalls mid-frame.
module eth_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int IFG_CYCLES  = 12,
    parameter int STALL_LIMIT = 64
) (
    input  logic                      pll_clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_valid,
    input  logic [NUM_REQ-1:0]        s_last,
    output logic [NUM_REQ-1:0]        s_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_valid,
    output logic                      m_last,
    output logic                      m_err,
    input  logic                      m_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [7:0]                abort_count
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int GAP_W   = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS,
        ST_ABORT,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [7:0]           abort_q, abort_d;

    logic [DATA_W-1:0]    lane_data [NUM_REQ];
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic [STALL_W-1:0]   stall_inc;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_data[i] = s_data[i*DATA_W +: DATA_W];
        end
    end

    assign sel_data  = lane_data[gidx_q];
    assign sel_valid = s_valid[gidx_q];
    assign sel_last  = s_last[gidx_q];
    assign stall_inc = stall_q + 1'b1;

    // Round-robin search begins one past the previous owner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && s_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        stall_d = stall_q;
        gap_d   = gap_q;
        abort_d = abort_q;
        s_ready = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_PASS;
                    gidx_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    stall_d          = '0;
                end
            end
            ST_PASS: begin
                m_data          = sel_data;
                m_valid         = sel_valid;
                m_last          = sel_last;
                s_ready[gidx_q] = m_ready;
                if (sel_valid && m_ready) begin
                    stall_d = '0;
                    if (sel_last) begin
                        state_d = ST_GAP;
                        last_d  = gidx_q;
                        grant_d = '0;
                        gap_d   = '0;
                    end
                end else if (!sel_valid) begin
                    // Only a starved source counts; downstream backpressure never does.
                    stall_d = stall_inc;
                    if (stall_inc == STALL_W'(STALL_LIMIT)) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_err   = 1'b1;
                if (m_ready) begin
                    state_d = ST_DRAIN;
                    if (abort_q != 8'hFF) begin
                        abort_d = abort_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                s_ready[gidx_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d = ST_GAP;
                    last_d  = gidx_q;
                    grant_d = '0;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(IFG_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            stall_q <= '0;
            gap_q   <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign abort_count = abort_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus randomized traffic
// compared against a frame-level round-robin reference model.
module tb_eth_tx_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int IFG  = 12;
    localparam int SLIM = 64;

    logic                 pll_clk = 1'b0;
    logic                 rst_n   = 1'b1;
    logic [NREQ*DW-1:0]   s_data;
    logic [NREQ-1:0]      s_valid;
    logic [NREQ-1:0]      s_last;
    logic [NREQ-1:0]      s_ready;
    logic [DW-1:0]        m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_err;
    logic                 m_ready;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic [7:0]           abort_count;

    eth_tx_arbiter #(
        .NUM_REQ(NREQ), .DATA_W(DW), .IFG_CYCLES(IFG), .STALL_LIMIT(SLIM)
    ) dut (
        .pll_clk(pll_clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
        .m_ready(m_ready), .grant(grant), .busy(busy), .abort_count(abort_count)
    );

    always #5 pll_clk = ~pll_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-lane byte queues {last, data}: lq feeds the DUT, mq feeds the reference model.
    logic [8:0]  lq [NREQ][$];
    logic [8:0]  mq [NREQ][$];
    int          stall_left [NREQ];
    int          sent [NREQ];
    bit          bubbles_en;
    int          mr_mode;
    int          mdl_last;

    // Output beat log entries {grant, err, last, data}.
    logic [11:0] log_q [$];
    int          log_cyc [$];
    logic [11:0] exp_q [$];
    logic        busy_log [4096];
    logic [1:0]  grant_log [4096];
    logic [1:0]  grant_s;
    logic [1:0]  sready_s;
    logic        mr_s;
    logic        busy_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        logic [NREQ-1:0]    v;
        logic [NREQ-1:0]    l;
        logic [NREQ*DW-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stall_left[i] > 0) begin
                stall_left[i]--;
            end else if (lq[i].size() > 0) begin
                v[i]          = 1'b1;
                d[i*DW +: DW] = lq[i][0][7:0];
                l[i]          = lq[i][0][8];
            end
        end
        s_valid = v;
        s_last  = l;
        s_data  = d;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] hs;
        logic [8:0]      b;
        @(negedge pll_clk);
        grant_s  = grant;
        sready_s = s_ready;
        mr_s     = m_ready;
        busy_s   = busy;
        if (cyc < 4096) begin
            busy_log[cyc]  = busy;
            grant_log[cyc] = grant;
        end
        if (m_valid && m_ready) begin
            log_q.push_back({grant, m_err, m_last, m_data});
            log_cyc.push_back(cyc);
        end
        hs = s_valid & s_ready;
        @(posedge pll_clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && lq[i].size() > 0) begin
                b = lq[i].pop_front();
                sent[i]++;
                if (bubbles_en && !b[8] && $urandom_range(3) == 0)
                    stall_left[i] = $urandom_range(3, 1);
            end
        end
    endtask

    task automatic step();
        case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = !m_ready;
            2: m_ready = ($urandom_range(3) != 0);
            default: ;
        endcase
        drive();
        cycle();
    endtask

    task automatic add_frame(input int lane, input int len, input logic [7:0] base,
                             input bit rnd, input bit to_model);
        logic [8:0] e;
        for (int k = 0; k < len; k++) begin
            e[8]   = (k == len - 1);
            e[7:0] = rnd ? 8'($urandom) : 8'(base + 8'(k) * 8'h11);
            lq[lane].push_back(e);
            if (to_model) mq[lane].push_back(e);
        end
    endtask

    function automatic bit model_pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Whole frames leave in round-robin order starting after the previous owner.
    task automatic build_expected();
        int         ln;
        int         c;
        logic [8:0] b;
        exp_q.delete();
        while (model_pending()) begin
            ln = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (mdl_last + k) % NREQ;
                if (ln < 0 && mq[c].size() > 0) ln = c;
            end
            do begin
                b = mq[ln].pop_front();
                exp_q.push_back({2'(1 << ln), 1'b0, b[8], b[7:0]});
            end while (!b[8]);
            mdl_last = ln;
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, " beat count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s beat%0d", tag, i), log_q[i], exp_q[i]);
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            lq[i].delete();
            mq[i].delete();
            stall_left[i] = 0;
            sent[i]       = 0;
        end
        bubbles_en = 1'b0;
        repeat (3) @(posedge pll_clk);
        #1;
        rst_n    = 1'b1;
        mdl_last = NREQ - 1;
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((lq[0].size() > 0 || lq[1].size() > 0 || busy_s) && n < budget);
        check({tag, " finished within budget"}, (n < budget), 1);
    endtask

    initial begin
        int c0;
        int lastc;
        int n;
        int hold_bad;
        bit stalled;

        mr_mode = 0; m_ready = 1'b0; bubbles_en = 1'b0;
        s_valid = 2'b11; s_last = '0; s_data = '0;
        #1 rst_n = 1'b0;
        #10;
        check("reset grant", grant, 0);
        check("reset busy", busy, 0);
        check("reset s_ready", s_ready, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_last", m_last, 0);
        check("reset m_err", m_err, 0);
        check("reset m_data", m_data, 0);
        check("reset abort_count", abort_count, 0);

        // Single 4-byte frame from lane 0.
        do_reset();
        add_frame(0, 4, 8'h11, 0, 1);
        c0 = cyc;
        mr_mode = 0;
        run_until_idle("single", 100);
        check("single grant before", grant_log[c0], 2'b00);
        check("single grant after", grant_log[c0+1], 2'b01);
        check("single busy before", busy_log[c0], 0);
        check("single busy after", busy_log[c0+1], 1);
        check("single beat count raw", log_cyc.size(), 4);
        if (log_cyc.size() == 4) begin
            lastc = log_cyc[3];
            check("single first beat cycle", log_cyc[0], c0 + 1);
            check("single last beat cycle", lastc, c0 + 4);
            check("single grant cleared in gap", grant_log[lastc+1], 2'b00);
            check("single busy last gap", busy_log[lastc+IFG], 1);
            check("single busy idle", busy_log[lastc+IFG+1], 0);
        end
        build_expected();
        compare_log("single");

        // Contention: both lanes always have frames queued.
        do_reset();
        add_frame(0, 3, 8'hA0, 0, 1);
        add_frame(1, 3, 8'hC0, 0, 1);
        add_frame(0, 3, 8'hB0, 0, 1);
        add_frame(1, 3, 8'hD0, 0, 1);
        run_until_idle("contend", 300);
        if (log_cyc.size() == 12) begin
            for (int f = 0; f < 3; f++)
                check($sformatf("contend spacing%0d", f),
                      log_cyc[3*f+3] - log_cyc[3*f+2], IFG + 2);
        end
        build_expected();
        compare_log("contend");

        // Backpressure on lane 1: long m_ready hold, then toggling.
        add_frame(1, 6, 8'h51, 0, 1);
        mr_mode = 3;
        m_ready = 1'b0;
        hold_bad = 0;
        repeat (200) begin
            step();
            if (grant_s == 2'b10 && sready_s[1] !== 1'b0) hold_bad++;
        end
        check("bp hold s_ready", hold_bad, 0);
        check("bp hold no beats", log_q.size(), 0);
        check("bp hold grant", grant_s, 2'b10);
        mr_mode = 1;
        n = 0;
        while (lq[1].size() > 0 && n < 60) begin
            step();
            n++;
            if (grant_s == 2'b10) check("bp s_ready mirrors m_ready", sready_s[1], mr_s);
        end
        mr_mode = 0;
        run_until_idle("bp", 100);
        check("bp abort_count", abort_count, 0);
        build_expected();
        compare_log("bp");

        // Stall abort: lane 0 starves for exactly STALL_LIMIT cycles after two bytes.
        add_frame(0, 6, 8'hC0, 0, 0);
        sent[0] = 0;
        stalled = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (!stalled && sent[0] == 2) begin
                stall_left[0] = SLIM;
                stalled = 1'b1;
            end
        end while ((lq[0].size() > 0 || busy_s) && n < 400);
        check("abort finished within budget", (n < 400), 1);
        check("abort drained", lq[0].size(), 0);
        check("abort abort_count", abort_count, 1);
        if (log_cyc.size() == 3)
            check("abort beat timing", log_cyc[2] - log_cyc[1], SLIM + 1);
        exp_q.delete();
        exp_q.push_back({2'b01, 1'b0, 1'b0, 8'hC0});
        exp_q.push_back({2'b01, 1'b0, 1'b0, 8'hD1});
        exp_q.push_back({2'b01, 1'b1, 1'b1, 8'h00});
        compare_log("abort");
        mdl_last = 0;

        // Limit race: the source returns on the cycle the limit would be reached.
        add_frame(0, 4, 8'h20, 0, 1);
        sent[0] = 0;
        stalled = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (!stalled && sent[0] == 2) begin
                stall_left[0] = SLIM - 1;
                stalled = 1'b1;
            end
        end while ((lq[0].size() > 0 || busy_s) && n < 400);
        check("race finished within budget", (n < 400), 1);
        check("race abort_count", abort_count, 1);
        if (log_cyc.size() == 4)
            check("race resume timing", log_cyc[2] - log_cyc[1], SLIM);
        build_expected();
        compare_log("race");

        // Asynchronous reset in the middle of a lane 1 frame.
        add_frame(1, 6, 8'h70, 0, 0);
        sent[1] = 0;
        n = 0;
        while (sent[1] < 2 && n < 50) begin
            step();
            n++;
        end
        check("rstmid reached mid-frame", sent[1], 2);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid grant", grant, 0);
        check("rstmid busy", busy, 0);
        check("rstmid m_valid", m_valid, 0);
        check("rstmid m_last", m_last, 0);
        check("rstmid m_data", m_data, 0);
        check("rstmid s_ready", s_ready, 0);
        check("rstmid abort_count", abort_count, 0);
        do_reset();
        add_frame(0, 2, 8'h01, 0, 1);
        add_frame(1, 2, 8'h81, 0, 1);
        run_until_idle("rstmid", 100);
        check("rstmid first owner", (log_q.size() > 0) ? log_q[0][11:10] : 2'b00, 2'b01);
        build_expected();
        compare_log("rstmid");

        // Randomized traffic with source bubbles and random backpressure.
        do_reset();
        bubbles_en = 1'b1;
        mr_mode = 2;
        for (int ln = 0; ln < NREQ; ln++) begin
            int nf;
            nf = $urandom_range(5, 3);
            for (int f = 0; f < nf; f++) add_frame(ln, $urandom_range(6, 1), 8'h00, 1, 1);
        end
        run_until_idle("random", 3000);
        check("random abort_count", abort_count, 0);
        build_expected();
        compare_log("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-level round-robin arbiter that shares the single Ethernet TX byte stream (toward the PMOD PHY serializer) between `NUM_REQ` frame sources such as the UART bridge and the PipelineC packet generator. It grants one whole frame at a time, enforces an inter-frame gap after each frame, and aborts frames whose source stalls mid-frame. It sits between the frame sources and the MAC/serializer, in the `pll_clk` domain.

## Interface

- `NUM_REQ`, 2, number of requesting streams (2..8)
- `DATA_W`, 8, byte-stream width
- `IFG_CYCLES`, 12, idle cycles forced after every frame end (≥1)
- `STALL_LIMIT`, 64, consecutive source-starved cycles mid-frame before abort (≥2)

Ports:
- `pll_clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `s_data` in NUM_REQ*DATA_W: requester bytes; requester i at [i*DATA_W +: DATA_W]
- `s_valid` in NUM_REQ: per-requester beat valid
- `s_last` in NUM_REQ: per-requester final byte of frame
- `s_ready` out NUM_REQ: per-requester accept
- `m_data` out DATA_W: granted byte toward MAC
- `m_valid` out 1: output beat valid
- `m_last` out 1: output final byte
- `m_err` out 1: qualifies an abort beat (with m_last=1)
- `m_ready` in 1: MAC accept
- `grant` out NUM_REQ: one-hot current owner, 0 when none
- `busy` out 1: state ≠ IDLE
- `abort_count` out 8: saturating count of aborted frames

## Operation

- States: IDLE, PASS, ABORT, DRAIN, GAP.
- IDLE: no output beats, all s_ready=0. If any s_valid set, select winner by round-robin: search starts at index (last_grant+1) mod NUM_REQ, wrapping; register `grant` and enter PASS. last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- PASS: combinational pass-through of granted lane: m_data/m_valid/m_last from lane g, m_err=0, s_ready[g]=m_ready, other s_ready=0. Handshake = m_valid & m_ready. Handshake with m_last=1 → GAP, last_grant←g, grant←0.
- Stall counter (width clog2(STALL_LIMIT+1)) counts PASS cycles with s_valid[g]=0; cleared on entering PASS and on any handshake. Cycles with s_valid[g]=1 & m_ready=0 are downstream backpressure and never count. Counter reaching STALL_LIMIT while s_valid[g]=0 → ABORT next cycle. If s_valid[g] rises in the same cycle the limit would be reached, the beat wins (no abort).
- ABORT: m_valid=1, m_last=1, m_err=1, m_data=0; all s_ready=0. On m_ready → DRAIN; abort_count increments (saturates at 255).
- DRAIN: m_valid=0; s_ready[g]=1, discarding lane-g bytes until a beat with s_valid[g]&s_last[g] → GAP, last_grant←g, grant←0.
- GAP: counts IFG_CYCLES cycles (cycle after frame end = gap cycle 1), all s_ready=0, m_valid=0; after last gap cycle → IDLE.
- Non-granted requesters are never accepted; their s_valid may stay asserted indefinitely.

## Timing

- Reset values: state IDLE, grant=0, busy=0, s_ready=0, m_valid=0, m_last=0, m_err=0, m_data=0, abort_count=0, last_grant=NUM_REQ-1, counters 0.
- Reset asserted mid-frame: immediate (asynchronous) return to reset values; partial frame is not terminated on output; the MAC discards it.
- Grant latency: s_valid seen in IDLE at cycle N → grant valid and first beat acceptable at N+1.
- PASS data latency 0 (combinational); s_ready to m_ready path combinational.
- Minimum frame-to-frame spacing: last beat at N, GAP N+1..N+IFG_CYCLES, IDLE at N+IFG_CYCLES+1, next grant at N+IFG_CYCLES+2.
- Abort: stall cycles 1..STALL_LIMIT, ABORT beat presented the following cycle, held until m_ready.
- busy is registered, high from grant cycle through final GAP cycle.

## Test plan

- Single source: req0 sends 4-byte frame 0x11,0x22,0x33,0x44 with m_ready=1 → grant=0b01 one cycle after s_valid, 4 output beats in consecutive cycles, m_last on 0x44, then 12 idle cycles before IDLE.
- Contention: req0 and req1 both valid continuously with 3-byte frames → output frames alternate 0,1,0,1; each separated by exactly IFG_CYCLES+1 non-beat cycles.
- Backpressure: m_ready toggles 1,0,1,0 during req1 frame with s_valid held for 200 cycles → no abort, bytes intact and in order, s_ready[1] mirrors m_ready.
- Stall abort: req0 sends 2 bytes then drops s_valid for 64 cycles → error beat (m_last=1, m_err=1, m_data=0), abort_count=1, remaining req0 bytes through s_last consumed with m_valid=0, then GAP.
- Limit race: s_valid[0] reasserts exactly on stall cycle 64 → beat forwarded, no abort, abort_count unchanged.
- Reset mid-frame: assert rst_n=0 after 2 bytes of req1 frame → all outputs 0 asynchronously; after release, req0 and req1 both valid → req0 granted first.
